mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, release is sampled on clk.
REQ-004 req0, req1  input  1 each  access request from port 0 (processor) and port 1 (loader/debug).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read, qualified by reqN.
REQ-006 adr0, adr1  input  ADDR_W each  access address.
REQ-007 wd0, wd1  input  DATA_W each  write data.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: the port's access is on the memory bus this cycle.
REQ-009 rvalid0, rvalid1  output  1 each  one-cycle pulse: rdata holds that port's read result.
REQ-010 rdata  output  DATA_W  registered read data, shared by both ports.
REQ-011 mem_we  output  1  memory write strobe.
REQ-012 mem_adr  output  ADDR_W  memory address.
REQ-013 mem_wd  output  DATA_W  memory write data.
REQ-014 mem_rd  input  DATA_W  memory read data, combinational from mem_adr.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; one access in flight at most.
REQ-016 IDLE: no reqN high -> stay IDLE; any reqN high -> ACCESS, latching winner index, weN, adrN, wdN into internal registers on that edge.
REQ-017 Arbitration: one request -> that port wins; both -> round-robin, the port not granted last wins; last-grant pointer updates on every IDLE->ACCESS edge.
REQ-018 ACCESS lasts exactly one cycle: gnt of winner = 1, mem_adr = latched address, mem_wd = latched data, mem_we = latched we.
REQ-019 ACCESS read: rdata <= mem_rd at end of cycle, next state RESP.
REQ-020 ACCESS write: rdata unchanged, next state IDLE.
REQ-021 RESP lasts exactly one cycle: rvalid of winner = 1, then IDLE.
REQ-022 Latency: request sampled in IDLE at cycle n -> gnt in n+1; read rvalid in n+2; next request sampled at n+2 (write) or n+3 (read).
REQ-023 Outside ACCESS: mem_we = 0, gnt0 = gnt1 = 0; mem_adr and mem_wd hold last latched values.
REQ-024 rvalid0/rvalid1 are 0 outside RESP; rdata holds last read value until next read completes.
REQ-025 gnt0 and gnt1 never both 1; rvalid0 and rvalid1 never both 1.
REQ-026 Requester holds reqN, weN, adrN, wdN stable until its gntN; changes after the IDLE sampling edge do not affect the latched access, which always completes.
REQ-027 Requests arriving in ACCESS or RESP are not latched; they are arbitrated at the next IDLE cycle.
REQ-028 A port holding reqN high after gntN is treated as a new request.

Reset
REQ-029 reset = 0: state = IDLE, last-grant pointer = port 1 (port 0 wins first tie), gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, mem_we = 0, mem_adr = 0, mem_wd = 0, rdata = 0, latched registers = 0, all asynchronously.
REQ-030 Reset during ACCESS drops mem_we immediately, abandons the access, and produces no rvalid; reset during RESP suppresses that rvalid.
REQ-031 After reset release, first IDLE->ACCESS transition occurs no earlier than the first rising edge with reset = 1.

Verification
REQ-032 Port 0 read adr=0x10, memory holds 0xDEADBEEF at 0x10 -> gnt0 at n+1 with mem_adr=0x10, mem_we=0; rvalid0 at n+2 with rdata=0xDEADBEEF.
REQ-033 Port 1 write adr=0x20 wd=0x12345678 -> gnt1 at n+1, mem_we=1 for exactly one cycle; subsequent port 0 read of 0x20 returns 0x12345678.
REQ-034 req0 and req1 held high continuously from reset release, all reads -> grant order 0,1,0,1; no cycle with both gnt or both rvalid high.
REQ-035 reset driven low mid-ACCESS of a port 0 write to 0x30 (old value 0x0) -> mem_we falls without a clock edge, no rvalid, 0x30 still reads 0x0 after reset release.
REQ-036 Port 0 changes adr0 from 0x40 to 0x44 one cycle after IDLE sampling -> ACCESS uses 0x40; rvalid0 returns data of 0x40.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single asynchronous-read memory. Port 0 is the
// processor, port 1 the loader/debug port. At most one access is in flight:
// a request is sampled in IDLE, placed on the memory bus for exactly one
// ACCESS cycle, and (for reads) answered with a one-cycle RESP. Simultaneous
// requests are resolved round-robin against the port granted last.
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            asynchronous active-low reset
//   req0/req1        access request per port
//   we0/we1          1 = write, 0 = read (qualified by reqN)
//   adr0/adr1        access address per port
//   wd0/wd1          write data per port
//   gnt0/gnt1        one-cycle pulse: that port's access is on the bus
//   rvalid0/rvalid1  one-cycle pulse: rdata holds that port's read result
//   rdata            registered read data shared by both ports
//   mem_we           memory write strobe
//   mem_adr          memory address
//   mem_wd           memory write data
//   mem_rd           memory read data, combinational from mem_adr
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] adr0,
    input  logic [ADDR_W-1:0] adr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;   // port granted most recently
    logic                win_q, win_d;     // port owning the access in flight
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                winner;
    logic [1:0]          gnt_v;
    logic [1:0]          rvalid_v;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;   // port 0 wins the first tie
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last wins.
    // -------------------------------------------------------------------------
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_q;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    last_d  = winner;
                    win_d   = winner;
                    we_d    = winner ? we1  : we0;
                    adr_d   = winner ? adr1 : adr0;
                    wd_d    = winner ? wd1  : wd0;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    rdata_d = mem_rd;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-port strobes. Decoded straight from the state register so that an
    // asynchronous reset removes them without waiting for a clock edge.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_v[gi]    = (state_q == ACCESS) && (win_q == 1'(gi));
            assign rvalid_v[gi] = (state_q == RESP)   && (win_q == 1'(gi));
        end
    endgenerate

    assign gnt0    = gnt_v[0];
    assign gnt1    = gnt_v[1];
    assign rvalid0 = rvalid_v[0];
    assign rvalid1 = rvalid_v[1];

    assign mem_we  = (state_q == ACCESS) && we_q;
    // Address and data keep showing the last latched access between cycles.
    assign mem_adr = adr_q;
    assign mem_wd  = wd_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] adr0, adr1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_adr, mem_wd, mem_rd;

    logic [31:0] mem [256];

    int n_cmp;
    int n_err;
    logic [31:0] last_rd;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .adr0    (adr0),
        .adr1    (adr1),
        .wd0     (wd0),
        .wd1     (wd1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .mem_we  (mem_we),
        .mem_adr (mem_adr),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple memory: asynchronous read, write on the rising edge.
    assign mem_rd = mem[mem_adr[7:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_adr[7:0]] = mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } txn_t;

    // One complete access from IDLE back to IDLE, checking every cycle.
    task automatic do_txn(input int idx, input txn_t t);
        if (t.port == 1'b0) begin
            req0 = 1'b1; we0 = t.we; adr0 = t.adr; wd0 = t.wd;
        end else begin
            req1 = 1'b1; we1 = t.we; adr1 = t.adr; wd1 = t.wd;
        end
        step();
        req0 = 1'b0;
        req1 = 1'b0;
        chk($sformatf("t%0d_gnt_own", idx),   32'(t.port ? gnt1 : gnt0), 32'd1);
        chk($sformatf("t%0d_gnt_other", idx), 32'(t.port ? gnt0 : gnt1), 32'd0);
        chk($sformatf("t%0d_mem_adr", idx),   mem_adr, t.adr);
        chk($sformatf("t%0d_mem_we", idx),    32'(mem_we), 32'(t.we));
        if (t.we) chk($sformatf("t%0d_mem_wd", idx), mem_wd, t.wd);
        step();
        if (!t.we) begin
            chk($sformatf("t%0d_rvalid_own", idx),   32'(t.port ? rvalid1 : rvalid0), 32'd1);
            chk($sformatf("t%0d_rvalid_other", idx), 32'(t.port ? rvalid0 : rvalid1), 32'd0);
            chk($sformatf("t%0d_rdata", idx), rdata, t.exp_rd);
            last_rd = t.exp_rd;
            step();
        end else begin
            chk($sformatf("t%0d_we_drop", idx), 32'(mem_we), 32'd0);
            chk($sformatf("t%0d_no_rvalid", idx), 32'({rvalid1, rvalid0}), 32'd0);
            chk($sformatf("t%0d_rdata_hold", idx), rdata, last_rd);
        end
        $display("txn %0d port=%0d we=%0d adr=0x%08h wd=0x%08h rdata=0x%08h",
                 idx, t.port, t.we, t.adr, t.wd, rdata);
    endtask

    txn_t tbl [8];
    int   order [4];
    int   gcount;

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_rd = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h14] = 32'h11112222;
        mem[8'h40] = 32'h40404040;
        mem[8'h44] = 32'h44444444;

        tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678,  32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h12345678};
        tbl[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF};
        tbl[4] = '{1'b0, 1'b1, 32'h34, 32'hCAFEF00D,  32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'h34, 32'h0,         32'hCAFEF00D};
        tbl[6] = '{1'b1, 1'b1, 32'h38, 32'h0BADC0DE,  32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h38, 32'h0,         32'h0BADC0DE};

        // ---------------- reset state, requests already pending ----------------
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        adr0 = 32'h10; adr1 = 32'h14; wd0 = 32'h0; wd1 = 32'h0;
        #2;
        chk("rst_gnt",     32'({gnt1, gnt0}), 32'd0);
        chk("rst_rvalid",  32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_mem_we",  32'(mem_we), 32'd0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_wd",  mem_wd, 32'h0);
        chk("rst_rdata",   rdata, 32'h0);
        step();
        chk("rst_edge_no_gnt", 32'({gnt1, gnt0}), 32'd0);
        $display("reset state checked");
        reset = 1'b1;

        // ---------------- both ports requesting continuously ----------------
        gcount = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("tie_c%0d_gnt_excl", c), 32'(gnt0 && gnt1), 32'd0);
            chk($sformatf("tie_c%0d_rv_excl", c),  32'(rvalid0 && rvalid1), 32'd0);
            if (gnt0 || gnt1) begin
                if (gcount < 4) order[gcount] = gnt1 ? 1 : 0;
                gcount++;
            end
            if (rvalid0) chk($sformatf("tie_c%0d_rd0", c), rdata, 32'hDEADBEEF);
            if (rvalid1) chk($sformatf("tie_c%0d_rd1", c), rdata, 32'h11112222);
            $display("tie cycle %0d gnt=%0d%0d rvalid=%0d%0d rdata=0x%08h",
                     c, gnt1, gnt0, rvalid1, rvalid0, rdata);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("tie_count", 32'(gcount), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gcount) chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(i % 2));
        end
        last_rd = 32'h11112222;
        step();

        // ---------------- table of single transactions ----------------
        for (int i = 0; i < 8; i++) do_txn(i, tbl[i]);

        // ---------------- address change after sampling ----------------
        req0 = 1'b1; we0 = 1'b0; adr0 = 32'h40;
        step();
        req0 = 1'b0;
        adr0 = 32'h44;
        chk("achg_gnt0", 32'(gnt0), 32'd1);
        chk("achg_mem_adr", mem_adr, 32'h40);
        step();
        chk("achg_rvalid0", 32'(rvalid0), 32'd1);
        chk("achg_rdata", rdata, 32'h40404040);
        $display("addr-change txn rdata=0x%08h", rdata);
        step();

        // ---------------- reset during RESP ----------------
        req1 = 1'b1; we1 = 1'b0; adr1 = 32'h10;
        step();
        req1 = 1'b0;
        step();
        chk("resp_rvalid1_before", 32'(rvalid1), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("resp_rvalid1_killed", 32'({rvalid1, rvalid0}), 32'd0);
        $display("reset during RESP rvalid=%0d%0d", rvalid1, rvalid0);
        step();
        reset = 1'b1;
        step();

        // ---------------- reset during write ACCESS ----------------
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'h30; wd0 = 32'hFFFFFFFF;
        step();
        req0 = 1'b0;
        chk("racc_mem_we_on", 32'(mem_we), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("racc_mem_we_off", 32'(mem_we), 32'd0);
        chk("racc_gnt_off", 32'({gnt1, gnt0}), 32'd0);
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("racc_no_rvalid%0d", c), 32'({rvalid1, rvalid0}), 32'd0);
        end
        $display("reset during ACCESS mem_we=%0d", mem_we);
        reset = 1'b1;
        last_rd = 32'h0;
        step();
        do_txn(8, '{1'b0, 1'b0, 32'h30, 32'h0, 32'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
